// File: rtl/io_supply_seq_pkg.sv
// Shared types and helpers for the IO-ring supply-domain sequencer.
package io_supply_seq_pkg;

    typedef enum logic [2:0] {
        OFF,
        UP_WAIT,
        UP_SETTLE,
        ON,
        DN_ISO,
        DN_WAIT,
        FAULT
    } seq_state_t;

    localparam int unsigned SYNC_DEPTH = 2;

    // Timer must hold the larger of the settle and timeout intervals without wrapping.
    function automatic int unsigned timer_width(input int unsigned settle, input int unsigned timeout);
        int unsigned longest;
        longest = (settle > timeout) ? settle : timeout;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/io_supply_seq_sync.sv
// Multi-bit flop-chain synchroniser for the pad-ring power-good detectors.
module io_supply_seq_sync
    import io_supply_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage [SYNC_DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SYNC_DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d_i;
            for (int unsigned i = 1; i < SYNC_DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q_o = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/io_supply_sequencer.sv
// N-domain supply sequencer: ascending power-up, descending power-down, sticky fault.
// Optional IO_SUPPLY_SEQ_SYNC_EN inserts a 2-flop synchroniser on pg_i.
module io_supply_sequencer
    import io_supply_seq_pkg::*;
#(
    parameter int unsigned N_DOMAINS      = 4,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        pwr_req_i,
    input  logic [N_DOMAINS-1:0]        pg_i,
    output logic [N_DOMAINS-1:0]        en_o,
    output logic [N_DOMAINS-1:0]        iso_o,
    output logic                        ready_o,
    output logic                        busy_o,
    output logic                        err_o,
    output logic [$clog2(N_DOMAINS):0]  err_idx_o
);

    localparam int unsigned TW = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam int unsigned EW = $clog2(N_DOMAINS) + 1;
    localparam logic [IW-1:0] LAST_IDX    = IW'(N_DOMAINS - 1);
    localparam logic [TW-1:0] SETTLE_END  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT_CYCLES - 1);

    logic [N_DOMAINS-1:0] pg_s;

`ifdef IO_SUPPLY_SEQ_SYNC_EN
    io_supply_seq_sync #(.WIDTH(N_DOMAINS)) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (pg_i),
        .q_o  (pg_s)
    );
`else
    assign pg_s = pg_i;
`endif

    seq_state_t           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [N_DOMAINS-1:0] en_d, iso_d;
    logic                 err_d;
    logic [EW-1:0]        err_idx_d, fail_idx;

    always_comb begin
        fail_idx = '0;
        for (int unsigned i = N_DOMAINS; i > 0; i--) begin
            if (!pg_s[i-1]) fail_idx = EW'(i - 1);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        en_d      = en_o;
        iso_d     = iso_o;
        err_d     = err_o;
        err_idx_d = err_idx_o;
        case (state_q)
            OFF: if (pwr_req_i) begin
                state_d  = UP_WAIT;
                idx_d    = '0;
                en_d[0]  = 1'b1;
                timer_d  = '0;
            end
            UP_WAIT: begin
                if (pg_s[idx_q]) begin
                    state_d = UP_SETTLE;
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_END) begin
                    state_d   = FAULT;
                    err_idx_d = EW'(idx_q);
                end else if (!pwr_req_i) begin
                    state_d      = DN_ISO;
                    iso_d[idx_q] = 1'b1;
                    timer_d      = '0;
                end
            end
            UP_SETTLE: begin
                // Abort wins over completion so a dropped request never de-isolates.
                if (!pwr_req_i) begin
                    state_d      = DN_ISO;
                    iso_d[idx_q] = 1'b1;
                    timer_d      = '0;
                end else if (timer_q == SETTLE_END) begin
                    iso_d[idx_q] = 1'b0;
                    timer_d      = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ON;
                    end else begin
                        state_d     = UP_WAIT;
                        idx_d       = idx_q + 1'b1;
                        en_d[idx_d] = 1'b1;
                    end
                end
            end
            ON: begin
                if (pg_s != '1) begin
                    state_d   = FAULT;
                    err_idx_d = fail_idx;
                end else if (!pwr_req_i) begin
                    state_d         = DN_ISO;
                    idx_d           = LAST_IDX;
                    iso_d[LAST_IDX] = 1'b1;
                    timer_d         = '0;
                end
            end
            DN_ISO: if (timer_q == SETTLE_END) begin
                state_d     = DN_WAIT;
                en_d[idx_q] = 1'b0;
                timer_d     = '0;
            end
            DN_WAIT: begin
                if (!pg_s[idx_q]) begin
                    timer_d = '0;
                    if (idx_q == '0) begin
                        state_d = OFF;
                    end else begin
                        state_d      = DN_ISO;
                        idx_d        = idx_q - 1'b1;
                        iso_d[idx_d] = 1'b1;
                    end
                end else if (timer_q == TIMEOUT_END) begin
                    state_d   = FAULT;
                    err_idx_d = EW'(idx_q);
                end
            end
            FAULT: if (!pwr_req_i) begin
                state_d = OFF;
                err_d   = 1'b0;
            end
            default: state_d = OFF;
        endcase
        if (state_d == FAULT) begin
            en_d  = '0;
            iso_d = '1;
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= OFF;
            idx_q     <= '0;
            timer_q   <= '0;
            en_o      <= '0;
            iso_o     <= '1;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
            err_idx_o <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            en_o      <= en_d;
            iso_o     <= iso_d;
            ready_o   <= (state_d == ON);
            busy_o    <= (state_d inside {UP_WAIT, UP_SETTLE, DN_ISO, DN_WAIT});
            err_o     <= err_d;
            err_idx_o <= err_idx_d;
        end
    end

endmodule
